// File: rtl/simd_alu_issuer_pkg.sv
// Shared opcode encodings, FSM states and opcode helpers
// for the SIMD ALU issuer and the ALU it drives.
package simd_alu_issuer_pkg;

   localparam int SIMD_OPC_WIDTH = 5;

   localparam logic [4:0] ADD8    = 5'h00;
   localparam logic [4:0] ADD16   = 5'h01;
   localparam logic [4:0] ADD32   = 5'h02;
   localparam logic [4:0] ADD64   = 5'h03;
   localparam logic [4:0] SUB8    = 5'h04;
   localparam logic [4:0] SUB16   = 5'h05;
   localparam logic [4:0] SUB32   = 5'h06;
   localparam logic [4:0] SUB64   = 5'h07;
   localparam logic [4:0] S_ADD8  = 5'h08;
   localparam logic [4:0] S_ADD16 = 5'h09;
   localparam logic [4:0] S_ADD32 = 5'h0A;
   localparam logic [4:0] S_ADD64 = 5'h0B;
   localparam logic [4:0] S_SUB8  = 5'h0C;
   localparam logic [4:0] S_SUB16 = 5'h0D;
   localparam logic [4:0] S_SUB32 = 5'h0E;
   localparam logic [4:0] S_SUB64 = 5'h0F;

   typedef enum logic [1:0] {
      LANE_8,
      LANE_16,
      LANE_32,
      LANE_64
   } lane_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_CAPTURE,
      ST_PUSH_ERR
   } state_e;

   function automatic logic is_legal_opcode(
      input logic [SIMD_OPC_WIDTH-1:0] opc
   );
      case (opc)
         ADD8, ADD16, ADD32, ADD64,
         SUB8, SUB16, SUB32, SUB64,
         S_ADD8, S_ADD16, S_ADD32, S_ADD64,
         S_SUB8, S_SUB16, S_SUB32, S_SUB64:
            return 1'b1;
         default:
            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/simd_alu_rsp_fifo.sv
// Show-ahead response FIFO; output reads as zero while empty
// so downstream sees clean rsp_* fields.
module simd_alu_rsp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && ((cnt_q != FULL) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   assign valid_o = (cnt_q != '0);
   assign rdata_o = valid_o ? mem_q[rd_q] : '0;
   assign count_o = cnt_q;

endmodule

// File: rtl/simd_alu_issuer.sv
// Issues one tagged op at a time to the SIMD ALU, holds operands
// for the ALU latency, and queues tagged results for the consumer.
module simd_alu_issuer
   import simd_alu_issuer_pkg::*;
#(
   parameter int DATA_WIDTH  = 256,
   parameter int OPC_WIDTH   = 5,
   parameter int TAG_WIDTH   = 4,
   parameter int ALU_LATENCY = 1,
   parameter int RSP_DEPTH   = 4,
   parameter logic [OPC_WIDTH-1:0] IDLE_OPC = '1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [OPC_WIDTH-1:0]    req_opcode,
   input  logic [DATA_WIDTH-1:0]   req_a,
   input  logic [DATA_WIDTH-1:0]   req_b,
   input  logic [TAG_WIDTH-1:0]    req_tag,
   output logic [DATA_WIDTH-1:0]   alu_a,
   output logic [DATA_WIDTH-1:0]   alu_b,
   output logic [OPC_WIDTH-1:0]    alu_opcode,
   input  logic [DATA_WIDTH-1:0]   alu_out,
   input  logic [DATA_WIDTH/8-1:0] alu_ovf,
   input  logic [DATA_WIDTH/8-1:0] alu_udf,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic [DATA_WIDTH/8-1:0] rsp_ovf,
   output logic [DATA_WIDTH/8-1:0] rsp_udf,
   output logic [TAG_WIDTH-1:0]    rsp_tag,
   output logic                    rsp_err,
   output logic                    busy
);

   localparam int FW = DATA_WIDTH/8;
   localparam int EW = DATA_WIDTH + 2*FW + TAG_WIDTH + 1;
   localparam int CW = $clog2(RSP_DEPTH) + 1;
   localparam int LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

   state_e                state_q, state_d;
   logic [LW-1:0]         cnt_q, cnt_d;
   logic                  live_q;
   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic [OPC_WIDTH-1:0]  opc_q;
   logic [TAG_WIDTH-1:0]  tag_q;

   logic          accept, legal, push;
   logic [EW-1:0] push_word, head_word;
   logic [CW-1:0] fifo_cnt;

   assign legal  = is_legal_opcode(req_opcode);
   assign accept = req_valid && req_ready;

   // live_q keeps the request side closed until the first edge after reset
   assign req_ready = (state_q == ST_IDLE) && live_q
                   && (fifo_cnt < CW'(RSP_DEPTH));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = legal ? ST_DRIVE : ST_PUSH_ERR;
               cnt_d   = LW'(ALU_LATENCY - 1);
            end
         end
         ST_DRIVE: begin
            if (cnt_q == '0) state_d = ST_CAPTURE;
            else             cnt_d   = cnt_q - LW'(1);
         end
         ST_CAPTURE: begin
            push    = 1'b1;
            state_d = ST_IDLE;
         end
         ST_PUSH_ERR: begin
            push    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         live_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         opc_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         live_q  <= 1'b1;
         if (accept) tag_q <= req_tag;
         if (accept && legal) begin
            a_q   <= req_a;
            b_q   <= req_b;
            opc_q <= req_opcode;
         end
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_opcode = ((state_q == ST_DRIVE) || (state_q == ST_CAPTURE))
                     ? opc_q : IDLE_OPC;
   assign busy       = (state_q != ST_IDLE);

   assign push_word = (state_q == ST_PUSH_ERR)
                    ? {{(DATA_WIDTH + 2*FW){1'b0}}, tag_q, 1'b1}
                    : {alu_out, alu_ovf, alu_udf, tag_q, 1'b0};

   simd_alu_rsp_fifo #(
      .WIDTH (EW),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (push_word),
      .pop_i   (rsp_valid && rsp_ready),
      .rdata_o (head_word),
      .valid_o (rsp_valid),
      .count_o (fifo_cnt)
   );

   assign {rsp_data, rsp_ovf, rsp_udf, rsp_tag, rsp_err} = head_word;

endmodule
